// File: rtl/tmds_pkg.sv
// Shared TMDS symbol constants, the TERC4 table and the per-cycle encoder mode.
// Used by tmds_encoder and tmds_terc4_lut; the TERC4 path is enabled with TMDS_TERC4_EN.
package tmds_pkg;

  localparam logic [9:0] CTRLTOKEN0 = 10'b1101010100;
  localparam logic [9:0] CTRLTOKEN1 = 10'b0010101011;
  localparam logic [9:0] CTRLTOKEN2 = 10'b0101010100;
  localparam logic [9:0] CTRLTOKEN3 = 10'b1010101011;

  localparam logic [9:0] VID_GB_BR = 10'b1011001100;
  localparam logic [9:0] VID_GB_G  = 10'b0100110011;
  localparam logic [9:0] DATA_GB   = 10'b0100110011;

  localparam logic [9:0] TERC4_LUT [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  typedef enum logic [2:0] {
    CTRL  = 3'd0,
    VID   = 3'd1,
    VGB   = 3'd2,
    DGB   = 3'd3,
    TERC4 = 3'd4
  } mode_e;

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] tok;
    case (c)
      2'b00:   tok = CTRLTOKEN0;
      2'b01:   tok = CTRLTOKEN1;
      2'b10:   tok = CTRLTOKEN2;
      2'b11:   tok = CTRLTOKEN3;
      default: tok = CTRLTOKEN0;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/tmds_terc4_lut.sv
// Pure combinational 4-bit to 10-bit TERC4 symbol lookup for HDMI data islands.
module tmds_terc4_lut
  import tmds_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [9:0] symbol
);

  // Table lookup of the TERC4 code word
  always_comb begin
    symbol = TERC4_LUT[nibble];
  end

endmodule

// File: rtl/tmds_encoder.sv
// Per-channel DVI/HDMI TMDS transmit encoder: 2-stage pipeline, running-disparity DC balance.
// Optional macro TMDS_TERC4_EN adds TERC4 data-island symbols (island/aux ports otherwise unused).
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter int CHANNEL = 0
) (
  input  logic       pclk,
  input  logic       reset_n,
  input  logic       de,
  input  logic [7:0] din,
  input  logic       c0,
  input  logic       c1,
  input  logic       vgb,
  input  logic       dgb,
  input  logic       island,
  input  logic [3:0] aux,
  output logic [9:0] sdout,
  output logic [4:0] disparity
);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  // Transition-minimising stage: XNOR chain when din is ones-heavy, XOR chain otherwise
  function automatic logic [8:0] make_qm(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && (d[0] == 1'b0));
    q        = 9'd0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  mode_e             mode_d, mode_q;
  logic [8:0]        q_m_d, q_m_q;
  logic [1:0]        ctl_d, ctl_q;
  logic [9:0]        sdout_d, sdout_q;
  logic signed [4:0] cnt_d, cnt_q;

`ifdef TMDS_TERC4_EN
  logic [3:0] aux_d, aux_q;
  logic [3:0] terc4_sel_s;
  logic [9:0] terc4_sym_s;
`else
  logic       unused_terc4_s;
  assign unused_terc4_s = ^{island, aux};
`endif

  // Stage 1: resolve mode priority and build q_m
  always_comb begin
    mode_d = CTRL;
    if (vgb) begin
      mode_d = VGB;
    end else if (dgb) begin
      mode_d = DGB;
`ifdef TMDS_TERC4_EN
    end else if (island) begin
      mode_d = TERC4;
`endif
    end else if (de) begin
      mode_d = VID;
    end else begin
      mode_d = CTRL;
    end
    ctl_d = {c1, c0};
    if (mode_d == VID) begin
      q_m_d = make_qm(din);
    end else begin
      q_m_d = 9'd0;
    end
`ifdef TMDS_TERC4_EN
    aux_d = aux;
`endif
  end

  // Stage 1 registers
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= CTRL;
      q_m_q  <= 9'd0;
      ctl_q  <= 2'b00;
`ifdef TMDS_TERC4_EN
      aux_q  <= 4'd0;
`endif
    end else begin
      mode_q <= mode_d;
      q_m_q  <= q_m_d;
      ctl_q  <= ctl_d;
`ifdef TMDS_TERC4_EN
      aux_q  <= aux_d;
`endif
    end
  end

`ifdef TMDS_TERC4_EN
  // Channel-0 data guard band reuses the TERC4 table with {1,1,c1,c0}
  assign terc4_sel_s = (mode_q == TERC4) ? aux_q : {2'b11, ctl_q};

  tmds_terc4_lut u_terc4_lut (
    .nibble (terc4_sel_s),
    .symbol (terc4_sym_s)
  );
`endif

  logic              q8_s;
  logic [3:0]        n1_s, n0_s;
  logic signed [4:0] n1_v, n0_v;

  assign q8_s = q_m_q[8];
  assign n1_s = popcount8(q_m_q[7:0]);
  assign n0_s = 4'd8 - n1_s;
  assign n1_v = $signed({1'b0, n1_s});
  assign n0_v = $signed({1'b0, n0_s});

  // Stage 2: choose output symbol and update running disparity
  always_comb begin
    sdout_d = CTRLTOKEN0;
    cnt_d   = 5'sd0;
    case (mode_q)
      VID: begin
        if ((cnt_q == 5'sd0) || (n1_s == n0_s)) begin
          sdout_d = {~q8_s, q8_s, (q8_s ? q_m_q[7:0] : ~q_m_q[7:0])};
          cnt_d   = q8_s ? (cnt_q + n1_v - n0_v) : (cnt_q + n0_v - n1_v);
        end else if ((!cnt_q[4] && (n1_s > n0_s)) || (cnt_q[4] && (n0_s > n1_s))) begin
          sdout_d = {1'b1, q8_s, ~q_m_q[7:0]};
          cnt_d   = cnt_q + (q8_s ? 5'sd2 : 5'sd0) + n0_v - n1_v;
        end else begin
          sdout_d = {1'b0, q8_s, q_m_q[7:0]};
          cnt_d   = cnt_q - (q8_s ? 5'sd0 : 5'sd2) + n1_v - n0_v;
        end
      end
      VGB: begin
        if (CHANNEL == 1) begin
          sdout_d = VID_GB_G;
        end else begin
          sdout_d = VID_GB_BR;
        end
        cnt_d = 5'sd0;
      end
      DGB: begin
        if (CHANNEL == 0) begin
`ifdef TMDS_TERC4_EN
          sdout_d = terc4_sym_s;
`else
          sdout_d = ctrl_token(ctl_q);
`endif
        end else begin
          sdout_d = DATA_GB;
        end
        cnt_d = 5'sd0;
      end
      TERC4: begin
`ifdef TMDS_TERC4_EN
        sdout_d = terc4_sym_s;
`else
        sdout_d = ctrl_token(ctl_q);
`endif
        cnt_d = 5'sd0;
      end
      CTRL: begin
        sdout_d = ctrl_token(ctl_q);
        cnt_d   = 5'sd0;
      end
      default: begin
        sdout_d = CTRLTOKEN0;
        cnt_d   = 5'sd0;
      end
    endcase
  end

  // Stage 2 registers drive the serializer directly
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      sdout_q <= CTRLTOKEN0;
      cnt_q   <= 5'sd0;
    end else begin
      sdout_q <= sdout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sdout     = sdout_q;
  assign disparity = cnt_q;

endmodule
